// File: rtl/tdc_sched.sv
// Round-robin scheduler for NCHAN TDC channels: grants one completed capture per cycle
// into a small result FIFO and pulses the granted channel's rearm the following cycle.
module tdc_sched #(
    parameter int NCHAN = 4,
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                en_i,
    input  logic [NCHAN-1:0]    mask_i,
    input  logic [NCHAN-1:0]    done_i,
    input  logic [NCHAN*TW-1:0] time_i,
    output logic [NCHAN-1:0]    rearm_o,
    input  logic                rd_i,
    output logic                valid_o,
    output logic [TW+1:0]       data_o,
    output logic [2:0]          count_o,
    output logic                stall_o
);
    localparam int CW = $clog2(NCHAN);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t           state_q, state_d;
    logic [NCHAN-1:0] inflight_q;
    logic [CW-1:0]    last_q;
    logic             stall_q;
    logic [TW+1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q;

    logic             run;
    logic             full, empty;
    logic [NCHAN-1:0] pending;
    logic             gnt_vld;
    logic [CW-1:0]    gnt_idx;
    logic             do_grant, do_pop;

    assign full    = (count_q == 3'(DEPTH));
    assign empty   = (count_q == 3'd0);
    assign pending = done_i & mask_i & ~inflight_q;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        rearm_o = inflight_q;
        case (state_q)
            IDLE: if (en_i) state_d = ARM;
            ARM: begin
                rearm_o = inflight_q | mask_i;
                state_d = en_i ? RUN : IDLE;
            end
            RUN: begin
                run = 1'b1;
                if (!en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Search starts one past the last grant; power-of-two NCHAN makes the wrap free.
    always_comb begin
        logic [CW-1:0] cand;
        cand    = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cand = last_q + CW'(i + 1);
            if (!gnt_vld && pending[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Fullness is judged at cycle start, so a same-cycle pop never makes room for a grant.
    assign do_grant = run && gnt_vld && !full;
    assign do_pop   = rd_i && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            last_q     <= CW'(NCHAN - 1);
            stall_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= do_grant ? (NCHAN'(1) << gnt_idx) : '0;
            stall_q    <= run && (pending != '0) && full;
            if (do_grant) begin
                last_q   <= gnt_idx;
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {2'b00, do_grant} - {2'b00, do_pop};
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries are meaningful.
    always_ff @(posedge wb_clk_i) begin
        if (do_grant && !wb_rst_i)
            mem[wr_ptr_q] <= {2'(gnt_idx), time_i[int'(gnt_idx)*TW +: TW]};
    end

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem[rd_ptr_q];
    assign count_o = count_q;
    assign stall_o = stall_q;
endmodule

// File: tb/tb_tdc_sched.sv
// Bench for tdc_sched: directed vector table, hand-written corner sequences, and a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_tdc_sched;
    localparam int NCHAN = 4;
    localparam int TW    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, rd;
    logic [3:0]  mask, done, rearm;
    logic [63:0] tm;
    logic        valid;
    logic [17:0] data;
    logic [2:0]  count;
    logic        stall;

    always #5 clk = ~clk;

    tdc_sched #(.NCHAN(NCHAN), .TW(TW), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .en_i    (en),
        .mask_i  (mask),
        .done_i  (done),
        .time_i  (tm),
        .rearm_o (rearm),
        .rd_i    (rd),
        .valid_o (valid),
        .data_o  (data),
        .count_o (count),
        .stall_o (stall)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs are applied 1 time unit after the edge; outputs are sampled 3 units later.
    task automatic drive(input logic r, input logic e, input logic [3:0] m, input logic [3:0] d,
                         input logic rdv);
        rst = r; en = e; mask = m; done = d; rd = rdv;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] dut_out();
        return {rearm, valid, count, stall, data};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic [3:0]  mask, done;
        logic        rd;
        logic [3:0]  rearm;
        logic [2:0]  count;
        logic        stall;
        logic [17:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [3:0] m, input logic [3:0] d, input logic r,
                       input logic [3:0] xr, input logic [2:0] xc, input logic xs,
                       input logic [17:0] xd);
        vec_t v;
        v.en = e; v.mask = m; v.done = d; v.rd = r;
        v.rearm = xr; v.count = xc; v.stall = xs; v.data = xd;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [17:0] q[$];
    int          m_mode;   // 0 idle, 1 arm, 2 run
    int          m_last;
    logic [3:0]  m_sched;
    logic        m_stall;

    function automatic logic [26:0] model_out(input logic [3:0] m);
        logic [3:0] r;
        r = m_sched | ((m_mode == 1) ? m : 4'h0);
        return {r, q.size() != 0, 3'(q.size()), m_stall, (q.size() != 0) ? q[0] : 18'h0};
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [3:0] m,
                              input logic [3:0] d, input logic rdv, input logic [63:0] t);
        int         n;
        logic [3:0] pend;
        logic [3:0] sched_n;
        if (r) begin
            m_mode = 0; q.delete(); m_last = NCHAN - 1; m_sched = 4'h0; m_stall = 1'b0;
        end else begin
            n       = q.size();
            pend    = d & m & ~m_sched;
            sched_n = 4'h0;
            m_stall = (m_mode == 2) && (pend != 0) && (n == DEPTH);
            if (rdv && n != 0) void'(q.pop_front());
            if (m_mode == 2 && pend != 0 && n < DEPTH) begin
                for (int i = 1; i <= NCHAN; i++) begin
                    int k;
                    k = (m_last + i) % NCHAN;
                    if (pend[k]) begin
                        q.push_back({2'(k), t[k*TW +: TW]});
                        sched_n[k] = 1'b1;
                        m_last = k;
                        break;
                    end
                end
            end
            m_sched = sched_n;
            case (m_mode)
                0:       m_mode = e ? 1 : 0;
                1:       m_mode = e ? 2 : 0;
                default: m_mode = e ? 2 : 0;
            endcase
        end
    endtask

    initial begin
        logic [3:0]  exp_r[6];
        logic        exp_s[6];
        logic [17:0] exp_d[6];
        logic [2:0]  exp_c[6];
        logic [3:0]  tdc;
        logic        en_r;
        logic [3:0]  mask_r;
        logic [26:0] exp_v;

        rst = 1'b1; en = 1'b0; mask = 4'h0; done = 4'h0; rd = 1'b0;
        tm  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        @(posedge clk); @(posedge clk); #1;

        //   en mask  done  rd | rearm cnt stall data
        add(0, 4'hF, 4'h0, 0, 4'h0, 0, 0, 18'h0);
        add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 18'h0);
        add(1, 4'hF, 4'h0, 0, 4'hF, 0, 0, 18'h0);      // ARM cycle
        add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 18'h0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 0, 0, 18'h0);      // grant ch0
        add(1, 4'hF, 4'hF, 0, 4'h1, 1, 0, 18'h00011);
        add(1, 4'hF, 4'hE, 0, 4'h2, 2, 0, 18'h00011);
        add(1, 4'hF, 4'hC, 0, 4'h4, 3, 0, 18'h00011);
        add(1, 4'hF, 4'h8, 0, 4'h8, 4, 0, 18'h00011);
        add(1, 4'hF, 4'h4, 0, 4'h0, 4, 0, 18'h00011);  // full, ch2 waits
        add(1, 4'hF, 4'h4, 0, 4'h0, 4, 1, 18'h00011);
        add(1, 4'hF, 4'h4, 1, 4'h0, 4, 1, 18'h00011);  // pop, still no grant
        add(1, 4'hF, 4'h4, 0, 4'h0, 3, 1, 18'h10022);  // ch2 granted
        add(1, 4'hF, 4'h4, 0, 4'h4, 4, 0, 18'h10022);
        add(1, 4'hF, 4'h0, 1, 4'h0, 4, 0, 18'h10022);
        add(1, 4'hF, 4'h0, 1, 4'h0, 3, 0, 18'h20033);
        add(1, 4'hF, 4'h0, 1, 4'h0, 2, 0, 18'h30044);
        add(1, 4'hF, 4'h0, 1, 4'h0, 1, 0, 18'h20033);
        add(1, 4'hF, 4'h8, 1, 4'h0, 0, 0, 18'h0);      // pop on empty ignored, grant ch3
        add(1, 4'hF, 4'h8, 0, 4'h8, 1, 0, 18'h30044);
        add(1, 4'hF, 4'h9, 0, 4'h0, 1, 0, 18'h30044);  // wrap: ch0 before ch3
        add(1, 4'hF, 4'h9, 0, 4'h1, 2, 0, 18'h30044);
        add(1, 4'hF, 4'h0, 0, 4'h8, 3, 0, 18'h30044);
        add(1, 4'hF, 4'h0, 1, 4'h0, 3, 0, 18'h30044);
        add(1, 4'hF, 4'h0, 1, 4'h0, 2, 0, 18'h00011);
        add(1, 4'hF, 4'h0, 1, 4'h0, 1, 0, 18'h30044);
        add(1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 18'h0);

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].en, tbl[i].mask, tbl[i].done, tbl[i].rd);
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'({tbl[i].rearm, tbl[i].count != 3'd0, tbl[i].count, tbl[i].stall, tbl[i].data}));
            tick();
        end

        // Masked channels 1 and 3 never granted; full FIFO raises stall.
        exp_r = '{4'h0, 4'h1, 4'h4, 4'h1, 4'h4, 4'h0};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 4'b0101, 4'hF, 1'b0);
            check($sformatf("mask_rearm%0d", i), 32'(rearm), 32'(exp_r[i]));
            check($sformatf("mask_stall%0d", i), 32'(stall), 32'(exp_s[i]));
            tick();
        end
        exp_d = '{18'h00011, 18'h20033, 18'h00011, 18'h20033, 18'h0, 18'h0};
        exp_c = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 4'b0101, 4'h0, 1'b1);
            check($sformatf("mask_data%0d", i), 32'(data), 32'(exp_d[i]));
            check($sformatf("mask_count%0d", i), 32'(count), 32'(exp_c[i]));
            tick();
        end

        // Reset in the middle of a grant cycle wins over everything.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
        check("rst_pre_count", 32'(count), 32'd3);
        check("rst_pre_rearm", 32'(rearm), 32'h2);
        tick();
        drive(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        check("rst_post_all", 32'(dut_out()), 32'd0);
        tick();
        drive(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        check("rst_then_arm", 32'(rearm), 32'hF);
        tick();

        // Randomized run against the reference model.
        tdc = 4'h0; en_r = 1'b1; mask_r = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_rd;
            r_rst = (i == 0) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 3) en_r = ~en_r;
            if ($urandom_range(0, 99) < 5) mask_r = 4'($urandom);
            r_rd = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tm   = {$urandom, $urandom};
            drive(r_rst, en_r, mask_r, tdc, r_rd);
            exp_v = model_out(mask_r);
            check($sformatf("rand%0d", i), 32'(dut_out()), 32'(exp_v));
            model_step(r_rst, en_r, mask_r, tdc, r_rd, tm);
            tdc = (tdc | 4'($urandom & $urandom)) & ~exp_v[26:23];
            if (r_rst) tdc = 4'h0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
